// File: rtl/parking_pkg.sv
// ---------------------------------------------------------------------------
// parking_pkg
//   Shared definitions for the parking request front-end:
//     PLATE_W / FLOOR_W : widths of a license plate (4 BCD digits) and floor.
//     req_kind_e        : kind of the request presented to the controller.
//     fifo_entry_t      : one queued in/out request (direction bit + plate).
//     plate_is_valid()  : every nibble is a BCD digit and the plate is non-zero.
// ---------------------------------------------------------------------------
package parking_pkg;

    localparam int PLATE_W = 16;
    localparam int FLOOR_W = 3;

    typedef enum logic [1:0] {
        REQ_IN   = 2'd0,
        REQ_OUT  = 2'd1,
        REQ_LEAK = 2'd2
    } req_kind_e;

    // is_out=0 -> entry request, is_out=1 -> exit request.
    typedef struct packed {
        logic               is_out;
        logic [PLATE_W-1:0] plate;
    } fifo_entry_t;

    localparam int ENTRY_W = $bits(fifo_entry_t);

    function automatic logic plate_is_valid(input logic [PLATE_W-1:0] plate);
        logic ok;
        ok = (plate != '0);
        for (int i = 0; i < PLATE_W / 4; i++) begin
            if (plate[i*4 +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/parking_req_fifo.sv
// ---------------------------------------------------------------------------
// parking_req_fifo
//   Synchronous FIFO holding queued in/out requests.
//   Ports:
//     clock, reset      : clock, asynchronous active-low reset
//     push_i, data_i    : write request and entry; a push while full is
//                         accepted only when a pop happens in the same cycle
//     pop_i             : remove head; ignored when empty
//     data_o            : current head entry (meaningful when !empty_o)
//     full_o, empty_o   : occupancy flags
//     count_o           : number of stored entries, 0..DEPTH
//     push_ok_o         : the push of this cycle is being accepted
// ---------------------------------------------------------------------------
module parking_req_fifo
    import parking_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push_i,
    input  logic [ENTRY_W-1:0] data_i,
    input  logic               pop_i,
    output logic [ENTRY_W-1:0] data_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               push_ok_o
);

    localparam int AW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push;
    logic               do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // When full, the slot freed by a same-cycle pop takes the new entry.
    assign do_push = push_i && (!full_o || do_pop);

    assign data_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign push_ok_o = do_push;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers are AW bits wide, so DEPTH being a power of 2 gives the wrap.
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/parking_request_queue.sv
// ---------------------------------------------------------------------------
// parking_request_queue
//   Validates raw panel inputs into requests, queues in/out requests in a
//   FIFO, keeps leakage evacuations in a one-entry priority slot, and
//   presents one request at a time to the parking controller.
//
//   Handshake: todo_exists=1 means a request is presented on todo_*; the
//   controller takes it by raising todo_pop in that cycle, and the item is
//   removed at the next rising edge. todo_pop while todo_exists=0 is ignored.
//   todo_* depend on registered state only, never on this cycle's inputs.
//
//   Ports:
//     clock, reset          : clock, asynchronous active-low reset
//     license_plate         : four BCD digits, [15:12] most significant
//     in_mode, out_mode     : entry / exit request, one request per cycle high
//     leakage, leakage_floor: leakage level and its floor (1..7)
//     todo_pop              : controller consumes the presented request
//     todo_exists           : a request is presented
//     todo_in/out/leak_move : kind of the presented request
//     todo_license_plate    : plate (0 for leakage requests)
//     todo_leak_floor       : leak floor (0 for in/out requests)
//     queue_count           : FIFO occupancy, excluding the priority slot
//     overflow              : pulse, a valid in/out request was dropped
//     bad_request           : pulse, a request was rejected
// ---------------------------------------------------------------------------
module parking_request_queue
    import parking_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [PLATE_W-1:0] license_plate,
    input  logic               in_mode,
    input  logic               out_mode,
    input  logic               leakage,
    input  logic [FLOOR_W-1:0] leakage_floor,
    input  logic               todo_pop,
    output logic               todo_exists,
    output logic               todo_in,
    output logic               todo_out,
    output logic               todo_leak_move,
    output logic [PLATE_W-1:0] todo_license_plate,
    output logic [FLOOR_W-1:0] todo_leak_floor,
    output logic [CNT_W-1:0]   queue_count,
    output logic               overflow,
    output logic               bad_request
);

    // Request validation
    logic plate_ok;
    logic one_dir;
    logic both_dir;
    logic push_req;
    logic plate_bad;

    assign plate_ok  = plate_is_valid(license_plate);
    assign one_dir   = in_mode ^ out_mode;
    assign both_dir  = in_mode & out_mode;
    assign push_req  = one_dir & plate_ok;
    assign plate_bad = one_dir & ~plate_ok;

    // Leak event: rising edge, or a new floor while leakage stays high.
    logic               prev_leak_q;
    logic [FLOOR_W-1:0] prev_floor_q;
    logic               leak_event;
    logic               leak_load;
    logic               leak_bad;

    assign leak_event = leakage & (~prev_leak_q | (leakage_floor != prev_floor_q));
    assign leak_load  = leak_event & (leakage_floor != '0);
    assign leak_bad   = leak_event & (leakage_floor == '0);

    // Priority slot and FIFO
    logic               slot_full_q,  slot_full_d;
    logic [FLOOR_W-1:0] slot_floor_q, slot_floor_d;

    fifo_entry_t        push_entry;
    fifo_entry_t        head_entry;
    logic [ENTRY_W-1:0] head_bits;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic               fifo_push_ok;
    logic [CNT_W-1:0]   fifo_count;

    // A pop always goes to the slot first; only then can it reach the FIFO.
    assign fifo_pop   = todo_pop & ~slot_full_q & ~fifo_empty;
    assign push_entry = '{is_out: out_mode, plate: license_plate};
    assign head_entry = fifo_entry_t'(head_bits);

    parking_req_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push_i    (push_req),
        .data_i    (push_entry),
        .pop_i     (fifo_pop),
        .data_o    (head_bits),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count),
        .push_ok_o (fifo_push_ok)
    );

    always_comb begin
        slot_full_d  = slot_full_q;
        slot_floor_d = slot_floor_q;
        // A new leak event beats a same-cycle pop of the slot: latest floor wins.
        if (leak_load) begin
            slot_full_d  = 1'b1;
            slot_floor_d = leakage_floor;
        end else if (todo_pop && slot_full_q) begin
            slot_full_d  = 1'b0;
            slot_floor_d = '0;
        end
    end

    // Status pulses
    logic overflow_q, overflow_d;
    logic bad_q, bad_d;

    assign overflow_d = push_req & ~fifo_push_ok;
    assign bad_d      = plate_bad | both_dir | leak_bad;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_leak_q  <= 1'b0;
            prev_floor_q <= '0;
            slot_full_q  <= 1'b0;
            slot_floor_q <= '0;
            overflow_q   <= 1'b0;
            bad_q        <= 1'b0;
        end else begin
            prev_leak_q  <= leakage;
            prev_floor_q <= leakage_floor;
            slot_full_q  <= slot_full_d;
            slot_floor_q <= slot_floor_d;
            overflow_q   <= overflow_d;
            bad_q        <= bad_d;
        end
    end

    // Output mux: decide the presented kind, then decode it.
    req_kind_e present_kind;
    logic      present_valid;

    always_comb begin
        present_valid = 1'b0;
        present_kind  = REQ_IN;
        if (slot_full_q) begin
            present_valid = 1'b1;
            present_kind  = REQ_LEAK;
        end else if (!fifo_empty) begin
            present_valid = 1'b1;
            present_kind  = head_entry.is_out ? REQ_OUT : REQ_IN;
        end
    end

    always_comb begin
        todo_exists        = present_valid;
        todo_in            = 1'b0;
        todo_out           = 1'b0;
        todo_leak_move     = 1'b0;
        todo_license_plate = '0;
        todo_leak_floor    = '0;
        if (present_valid) begin
            case (present_kind)
                REQ_LEAK: begin
                    todo_leak_move  = 1'b1;
                    todo_leak_floor = slot_floor_q;
                end
                REQ_OUT: begin
                    todo_out           = 1'b1;
                    todo_license_plate = head_entry.plate;
                end
                default: begin
                    todo_in            = 1'b1;
                    todo_license_plate = head_entry.plate;
                end
            endcase
        end
    end

    assign queue_count = fifo_count;
    assign overflow    = overflow_q;
    assign bad_request = bad_q;

endmodule

// File: doc/parking_request_queue.md
Name: parking_request_queue

Overview:
- Front-end stage directly upstream of parking_lot_top's controller.
- Samples the raw panel inputs (license_plate, in_mode, out_mode, leakage, leakage_floor) every cycle and validates them into requests.
- Queues the requests and presents them one at a time on the todo_* interface, using a valid/pop handshake.
- Leakage requests go into a one-entry priority slot and are always presented ahead of queued in/out requests.

Parameters:
- DEPTH, 8: FIFO entries for in/out requests; must be a power of 2, minimum 2.
- CNT_W, 4: width of the occupancy counter; equals log2(DEPTH)+1.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- license_plate  in  16  four BCD digits; [15:12] is the most significant digit.
- in_mode  in  1  entry request, sampled every cycle.
- out_mode  in  1  exit request, sampled every cycle.
- leakage  in  1  leakage level, may be held for many cycles.
- leakage_floor  in  3  floor of the leakage, valid range 1..7.
- todo_pop  in  1  controller consumes the presented request this cycle.
- todo_exists  out  1  a request is presented.
- todo_in  out  1  presented request is an entry.
- todo_out  out  1  presented request is an exit.
- todo_leak_move  out  1  presented request is a leakage evacuation.
- todo_license_plate  out  16  plate of the presented request; 0 for leakage requests.
- todo_leak_floor  out  3  floor of the presented leakage request; 0 otherwise.
- queue_count  out  CNT_W  number of FIFO entries; excludes the priority slot.
- overflow  out  1  one-cycle pulse: a valid in/out request was dropped because the FIFO was full.
- bad_request  out  1  one-cycle pulse: a request was rejected (invalid plate, in+out together, or bad floor).

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty, priority slot empty, leak edge register cleared. All outputs are 0, including queue_count, overflow and bad_request.
- Plate validity: every nibble must be <=9 and the plate must be non-zero. Otherwise the request is rejected and bad_request pulses.
- in_mode=1 and out_mode=1 in the same cycle: both are rejected and bad_request pulses once.
- Each cycle with exactly one of in_mode/out_mode high and a valid plate is one request. A level held for N cycles produces N requests; the upstream side supplies one-cycle strobes.
- Leak event: rising edge of leakage, or leakage_floor changing while leakage=1.
  - Event with floor in 1..7: loads the priority slot with that floor, overwriting any pending, unpopped leak request. The latest floor wins and no pulse is raised.
  - Event with floor=0: rejected and bad_request pulses.
  - The register tracking prev_leakage/prev_floor is cleared by reset.
- Presentation:
  - If the priority slot is full, present the leak request: todo_leak_move=1, todo_in=0, todo_out=0, todo_license_plate=0.
  - Otherwise present the FIFO head, if any.
  - todo_exists = slot full OR FIFO not empty. When todo_exists=0, all todo_* outputs are 0.
- Pop: todo_pop with todo_exists=1 removes the presented item at the clock edge. todo_pop with todo_exists=0 is ignored.
- Latency: a request sampled at edge k is presented after edge k, i.e. visible on todo_* in cycle k+1 when the queue was empty. There is no combinational path from inputs to todo_*.
- Full FIFO:
  - A push with no simultaneous FIFO pop is dropped and overflow pulses.
  - A push in the same cycle as a FIFO pop is accepted and the count is unchanged.
  - A pop that is consumed by the priority slot does not free a FIFO entry.
- Simultaneous leak event and in/out push: both are accepted; the leak goes to the slot and the in/out to the FIFO.
- Pop of the leak slot in the same cycle as a new leak event: the slot holds the new event.
- Pointers wrap modulo DEPTH. queue_count ranges 0..DEPTH.
- overflow and bad_request are registered and high for exactly one cycle per event.

Decomposition:
- Shared package parking_pkg holds:
  - PLATE_W=16 and FLOOR_W=3.
  - Request kind encoding: REQ_IN, REQ_OUT, REQ_LEAK.
  - Helper function plate_is_valid (BCD and non-zero check).
- Sub-module parking_req_fifo: synchronous FIFO of width 17 (kind bit + plate) and DEPTH entries, with push/pop/full/empty/count and simultaneous push+pop when full.
- The top of this block holds validation, leak edge detect, the priority slot and the output mux.

Test Plan:
- Reset then 1-cycle in_mode with plate 9423 -> next cycle todo_exists=1, todo_in=1, todo_license_plate=16'h9423, queue_count=1. Pop -> todo_exists=0, count=0.
- leakage=1, floor=4 held 5 cycles while in_mode pulses with plate 8754 -> todo_leak_move=1, floor=4 presented first and only once. After pop, the 8754 entry is presented.
- Push 9 valid requests (DEPTH=8) without pop -> queue_count=8, overflow pulses once on the 9th. Popped order matches push order for the first 8.
- FIFO full, push 5755 and pop in the same cycle -> overflow=0, count stays 8, and 5755 appears last.
- Plates 16'h9A23 and 0000, in+out together, and leak floor 0 -> bad_request pulses for each; queue and slot unchanged.
- Assert reset low mid-stream with 3 queued and the slot full -> immediately todo_exists=0 and queue_count=0. After release, a new request is presented normally.
